// File: rtl/power_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// power_sequencer
//   Power-state controller driven by one push button. Holding the button for
//   ON_HOLD_MS powers the main rail on. After the button is released, holding it
//   for OFF_HOLD_MS powers it off. With IDLE_MS != 0, power is also dropped after
//   IDLE_MS of no activity.
//
// Ports
//   clk        in   system clock
//   rst_on     in   asynchronous active-low reset
//   power_btn  in   raw button, asynchronous, 1 = pressed
//   activity   in   synchronous, 1 = user/motion input this cycle
//   power_on   out  1 while in ON_REL or ON
//   on_pulse   out  1-cycle pulse when power comes on
//   off_pulse  out  1-cycle pulse on any entry into OFF_REL
//   auto_off   out  sticky: last power-off came from the idle timeout
//   state      out  00 OFF, 01 ON_REL, 10 ON, 11 OFF_REL
// -----------------------------------------------------------------------------
module power_sequencer #(
    parameter int unsigned CLK_PER_MS  = 100000,
    parameter int unsigned ON_HOLD_MS  = 1000,
    parameter int unsigned OFF_HOLD_MS = 1000,
    parameter int unsigned IDLE_MS     = 10000
) (
    input  logic       clk,
    input  logic       rst_on,
    input  logic       power_btn,
    input  logic       activity,
    output logic       power_on,
    output logic       on_pulse,
    output logic       off_pulse,
    output logic       auto_off,
    output logic [1:0] state
);

    localparam logic [1:0] ST_OFF     = 2'b00;
    localparam logic [1:0] ST_ON_REL  = 2'b01;
    localparam logic [1:0] ST_ON      = 2'b10;
    localparam logic [1:0] ST_OFF_REL = 2'b11;

    localparam int unsigned      PRE_W     = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_MS - 1);
    localparam logic [15:0]      ON_LAST   = 16'(ON_HOLD_MS - 1);
    localparam logic [15:0]      OFF_LAST  = 16'(OFF_HOLD_MS - 1);
    // IDLE_MS == 0 disables the timeout; the compare value is then never used.
    localparam logic [15:0]      IDLE_LAST = (IDLE_MS == 0) ? 16'd0 : 16'(IDLE_MS - 1);

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic [PRE_W-1:0] pre_cnt_r;
    logic             tick_s;
    logic [15:0]      hold_cnt_r;
    logic [15:0]      idle_cnt_r;
    logic [1:0]       state_r;
    logic             power_on_r;
    logic             on_pulse_r;
    logic             off_pulse_r;
    logic             auto_off_r;

    logic [1:0]       state_nxt_s;
    logic [15:0]      hold_nxt_s;
    logic [15:0]      idle_nxt_s;
    logic             on_pulse_nxt_s;
    logic             off_pulse_nxt_s;
    logic             auto_off_nxt_s;

    assign tick_s    = (pre_cnt_r == PRE_LAST);
    assign power_on  = power_on_r;
    assign on_pulse  = on_pulse_r;
    assign off_pulse = off_pulse_r;
    assign auto_off  = auto_off_r;
    assign state     = state_r;

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge clk or negedge rst_on) begin
        if (!rst_on) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= power_btn;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Free-running millisecond prescaler.
    always_ff @(posedge clk or negedge rst_on) begin
        if (!rst_on) begin
            pre_cnt_r <= '0;
        end else if (tick_s) begin
            pre_cnt_r <= '0;
        end else begin
            pre_cnt_r <= pre_cnt_r + 1'b1;
        end
    end

    // Next-state, counter and pulse logic.
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_cnt_r;
        idle_nxt_s      = 16'd0;
        on_pulse_nxt_s  = 1'b0;
        off_pulse_nxt_s = 1'b0;
        auto_off_nxt_s  = auto_off_r;
        case (state_r)
            ST_OFF: begin
                if (!btn_sync_r) begin
                    hold_nxt_s = 16'd0;
                end else if (tick_s) begin
                    if (hold_cnt_r == ON_LAST) begin
                        state_nxt_s    = ST_ON_REL;
                        hold_nxt_s     = 16'd0;
                        on_pulse_nxt_s = 1'b1;
                        auto_off_nxt_s = 1'b0;
                    end else begin
                        hold_nxt_s = hold_cnt_r + 16'd1;
                    end
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            ST_ON_REL: begin
                hold_nxt_s = 16'd0;
                if (!btn_sync_r) begin
                    state_nxt_s = ST_ON;
                end else begin
                    state_nxt_s = ST_ON_REL;
                end
            end
            ST_ON: begin
                // Idle timeout first; a manual hold expiry below overrides it.
                if (IDLE_MS != 0) begin
                    if (activity || btn_sync_r) begin
                        idle_nxt_s = 16'd0;
                    end else if (tick_s) begin
                        if (idle_cnt_r == IDLE_LAST) begin
                            state_nxt_s     = ST_OFF_REL;
                            off_pulse_nxt_s = 1'b1;
                            auto_off_nxt_s  = 1'b1;
                        end else begin
                            idle_nxt_s = idle_cnt_r + 16'd1;
                        end
                    end else begin
                        idle_nxt_s = idle_cnt_r;
                    end
                end else begin
                    idle_nxt_s = 16'd0;
                end
                if (!btn_sync_r) begin
                    hold_nxt_s = 16'd0;
                end else if (tick_s) begin
                    if (hold_cnt_r == OFF_LAST) begin
                        state_nxt_s     = ST_OFF_REL;
                        hold_nxt_s      = 16'd0;
                        off_pulse_nxt_s = 1'b1;
                        auto_off_nxt_s  = auto_off_r;
                    end else begin
                        hold_nxt_s = hold_cnt_r + 16'd1;
                    end
                end else begin
                    hold_nxt_s = hold_cnt_r;
                end
            end
            ST_OFF_REL: begin
                // Wait for release so the off-hold cannot re-arm power-on.
                hold_nxt_s = 16'd0;
                if (!btn_sync_r) begin
                    state_nxt_s = ST_OFF;
                end else begin
                    state_nxt_s = ST_OFF_REL;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                hold_nxt_s  = 16'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_on) begin
        if (!rst_on) begin
            state_r     <= ST_OFF;
            hold_cnt_r  <= 16'd0;
            idle_cnt_r  <= 16'd0;
            power_on_r  <= 1'b0;
            on_pulse_r  <= 1'b0;
            off_pulse_r <= 1'b0;
            auto_off_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            idle_cnt_r  <= idle_nxt_s;
            power_on_r  <= (state_nxt_s == ST_ON_REL) || (state_nxt_s == ST_ON);
            on_pulse_r  <= on_pulse_nxt_s;
            off_pulse_r <= off_pulse_nxt_s;
            auto_off_r  <= auto_off_nxt_s;
        end
    end

endmodule

// File: tb/tb_power_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_power_sequencer
//   Directed bench for power_sequencer (CLK_PER_MS=4, ON_HOLD_MS=5,
//   OFF_HOLD_MS=3, IDLE_MS=8) plus a second instance built with IDLE_MS=0.
//   Expected pulse events (cycle, kind, state, power_on, auto_off) are queued by
//   the stimulus; a monitor pops one per observed pulse. cyc counts rising edges
//   since reset release; ticks are consumed on edges 4, 8, 12, ...
// -----------------------------------------------------------------------------
module tb_power_sequencer;

    typedef struct {
        int       cyc;
        logic     on_p;
        logic     off_p;
        logic [1:0] st;
        logic     pwr;
        logic     ao;
    } ev_t;

    logic       clk;
    logic       rst_on;
    logic       btn;
    logic       act;
    logic       power_on;
    logic       on_pulse;
    logic       off_pulse;
    logic       auto_off;
    logic [1:0] state;

    logic       btn2;
    logic       act2;
    logic       power_on2;
    logic       on_pulse2;
    logic       off_pulse2;
    logic       auto_off2;
    logic [1:0] state2;

    int  cyc;
    int  chk_cnt  = 0;
    int  pass_cnt = 0;
    int  off2_cnt = 0;
    ev_t exp_q[$];

    power_sequencer #(
        .CLK_PER_MS(4), .ON_HOLD_MS(5), .OFF_HOLD_MS(3), .IDLE_MS(8)
    ) dut (
        .clk(clk), .rst_on(rst_on), .power_btn(btn), .activity(act),
        .power_on(power_on), .on_pulse(on_pulse), .off_pulse(off_pulse),
        .auto_off(auto_off), .state(state)
    );

    power_sequencer #(
        .CLK_PER_MS(4), .ON_HOLD_MS(5), .OFF_HOLD_MS(3), .IDLE_MS(0)
    ) dut_noidle (
        .clk(clk), .rst_on(rst_on), .power_btn(btn2), .activity(act2),
        .power_on(power_on2), .on_pulse(on_pulse2), .off_pulse(off_pulse2),
        .auto_off(auto_off2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_on) begin
        if (!rst_on) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act_v, input int exp_v);
        chk_cnt++;
        if (act_v == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act_v, exp_v, cyc);
    endtask

    task automatic push(input int c, input logic on_p, input logic off_p,
                        input logic [1:0] st, input logic pwr, input logic ao);
        ev_t e;
        e.cyc = c; e.on_p = on_p; e.off_p = off_p; e.st = st; e.pwr = pwr; e.ao = ao;
        exp_q.push_back(e);
    endtask

    // Wait until the falling edge where cyc == n.
    task automatic at(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            chk_cnt++;
            $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
        end
    endtask

    // Scoreboard monitor: one queued expectation per observed pulse.
    always @(negedge clk) begin
        if (rst_on && (on_pulse || off_pulse)) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_pulse: got on=%0d off=%0d expected none (cyc %0d)",
                         on_pulse, off_pulse, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_cycle", cyc, e.cyc);
                chk("ev_on_pulse", int'(on_pulse), int'(e.on_p));
                chk("ev_off_pulse", int'(off_pulse), int'(e.off_p));
                chk("ev_state", int'(state), int'(e.st));
                chk("ev_power_on", int'(power_on), int'(e.pwr));
                chk("ev_auto_off", int'(auto_off), int'(e.ao));
            end
        end
    end

    // Any off pulse from the no-idle instance is counted.
    always @(negedge clk) begin
        if (off_pulse2) off2_cnt <= off2_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_power_on"}, int'(power_on), 0);
        chk({tag, "_on_pulse"}, int'(on_pulse), 0);
        chk({tag, "_off_pulse"}, int'(off_pulse), 0);
        chk({tag, "_auto_off"}, int'(auto_off), 0);
    endtask

    initial begin
        rst_on = 1'b0; btn = 1'b0; act = 1'b0; btn2 = 1'b0; act2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_noidle_state", int'(state2), 0);

        // 1: hold from reset -> on after 5th tick (edge 20)
        rst_on = 1'b1; btn = 1'b1;
        push(20, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        at(25);  chk("t1_state_held", int'(state), 1); chk("t1_power_on", int'(power_on), 1);
        at(30);  btn = 1'b0;
        at(32);  chk("t1_still_onrel", int'(state), 1);
        at(33);  chk("t1_on", int'(state), 2);

        // 3: hold 3 ticks in ON -> manual off at edge 48, then stay in OFF_REL
        at(36);  btn = 1'b1;
        push(48, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        at(88);  chk("t3_offrel_held", int'(state), 3); chk("t3_power_off", int'(power_on), 0);
        btn = 1'b0;
        at(90);  chk("t3_offrel_sync", int'(state), 3);
        at(91);  chk("t3_off", int'(state), 0);

        // 2: 3-tick press, release, then 5-tick press -> on at edge 128
        at(92);  btn = 1'b1;
        at(104); btn = 1'b0;
        at(108); btn = 1'b1;
        push(128, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        at(127); chk("t2_no_early_on", int'(state), 0);
        at(130); btn = 1'b0;

        // 4: idle timeout on 8th tick (edge 164)
        push(164, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        at(133); chk("t4_on", int'(state), 2);
        at(163); chk("t4_before_idle", int'(state), 2);
        at(166); chk("t4_off", int'(state), 0); chk("t4_auto_sticky", int'(auto_off), 1);
        at(168); btn = 1'b1;
        push(188, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        at(190); btn = 1'b0;
        at(193); chk("t4_repower", int'(state), 2); chk("t4_auto_cleared", int'(auto_off), 0);
        // activity on the 7th idle tick restarts the count -> off at edge 252
        at(219); act = 1'b1;
        at(220); act = 1'b0;
        push(252, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        at(224); chk("t4_restarted", int'(state), 2);
        at(251); chk("t4_before_idle2", int'(state), 2);

        // 5: async reset mid-hold (after 3 ticks)
        at(256); btn = 1'b1;
        at(270); rst_on = 1'b0;
        #1;      chk_all_zero("t5_rst_hold");
        @(negedge clk); @(negedge clk);
        rst_on = 1'b1;
        push(20, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        at(19);  chk("t5_full_hold_needed", int'(state), 0);
        at(30);  btn = 1'b0;
        at(33);  chk("t5_on", int'(state), 2); chk("t5_power_on", int'(power_on), 1);
        // async reset while ON
        at(40);  rst_on = 1'b0;
        #1;      chk_all_zero("t5_rst_on");
        @(negedge clk); @(negedge clk);
        rst_on = 1'b1; btn2 = 1'b1;

        // 6: IDLE_MS=0 instance stays on through 200 idle ticks
        at(10);  chk("t6_main_off", int'(state), 0);
        at(25);  chk("t6_noidle_onrel", int'(state2), 1); chk("t6_noidle_pwr", int'(power_on2), 1);
        at(30);  btn2 = 1'b0;
        at(33);  chk("t6_noidle_on", int'(state2), 2);
        at(900); chk("t6_noidle_still_on", int'(power_on2), 1);
        chk("t6_noidle_auto_off", int'(auto_off2), 0);
        chk("t6_noidle_state", int'(state2), 2);
        chk("t6_noidle_off_pulses", off2_cnt, 0);
        chk("t6_main_still_off", int'(state), 0);

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
